// File: rtl/stream_write_sequencer.sv
// stream_write_sequencer: serialises one D2Q9 node's nine post-collision
// distributions into single-port writes to the distribution memory.
// Optional feature macro: BOUNCE_BACK_EN. When it is defined, invalid lanes are
// written back to the source node in the opposite direction. When it is not
// defined, invalid lanes are skipped and counted.
module stream_write_sequencer #(
    parameter int GRID_DIM      = 256,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM) + 1,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [9*ADDRESS_WIDTH-1:0] write_addresses,
    input  logic [9*DATA_WIDTH-1:0]    f_post,
    input  logic [ADDRESS_WIDTH-2:0]   src_addr,
    output logic                       mem_we,
    output logic [3:0]                 mem_dir,
    output logic [ADDRESS_WIDTH-2:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_data,
    input  logic                       mem_ready,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                boundary_count
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LANE, DONE} state_t;

    state_t          r_state;
    logic [9*AW-1:0] r_addrs;
    logic [9*DW-1:0] r_fPost;
    logic [AW-2:0]   r_src;
    logic [3:0]      r_dir;
    logic            r_laneInvalid;
    logic            r_inReady;
    logic            r_memWe;
    logic [3:0]      r_memDir;
    logic [AW-2:0]   r_memAddr;
    logic [DW-1:0]   r_memData;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     r_boundaryCount;

    logic [9*AW-1:0] w_selAddrs;
    logic [9*DW-1:0] w_selData;
    logic [AW-2:0]   w_selSrc;
    logic [3:0]      w_nextDir;
    logic [AW-1:0]   w_lane;
    logic [DW-1:0]   w_laneData;
    logic            w_nextInvalid;
    logic            w_nextWe;
    logic [3:0]      w_nextMemDir;
    logic [AW-2:0]   w_nextMemAddr;
    logic [DW-1:0]   w_nextMemData;
    logic            w_retire;

`ifdef BOUNCE_BACK_EN
    function automatic logic [3:0] oppDir(input logic [3:0] d);
        case (d)
            4'd1:    oppDir = 4'd3;
            4'd2:    oppDir = 4'd4;
            4'd3:    oppDir = 4'd1;
            4'd4:    oppDir = 4'd2;
            4'd5:    oppDir = 4'd7;
            4'd6:    oppDir = 4'd8;
            4'd7:    oppDir = 4'd5;
            4'd8:    oppDir = 4'd6;
            default: oppDir = d;
        endcase
    endfunction
`endif

    // Work out the write fields for the lane presented next: lane 0 of the
    // incoming bundle while idle, otherwise the lane after the current one.
    always_comb begin
        w_selAddrs = r_addrs;
        w_selData  = r_fPost;
        w_selSrc   = r_src;
        w_nextDir  = r_dir + 4'd1;
        if (r_state == IDLE) begin
            w_selAddrs = write_addresses;
            w_selData  = f_post;
            w_selSrc   = src_addr;
            w_nextDir  = 4'd0;
        end
        w_lane     = '0;
        w_laneData = '0;
        for (int d = 0; d < 9; d++) begin
            if (w_nextDir == 4'(d)) begin
                w_lane     = w_selAddrs[(8-d)*AW +: AW];
                w_laneData = w_selData[(8-d)*DW +: DW];
            end
        end
        w_nextInvalid = w_lane[AW-1];
        w_nextMemData = w_laneData;
        w_nextMemAddr = w_nextInvalid ? w_selSrc : w_lane[AW-2:0];
`ifdef BOUNCE_BACK_EN
        w_nextWe     = 1'b1;
        w_nextMemDir = w_nextInvalid ? oppDir(w_nextDir) : w_nextDir;
`else
        w_nextWe     = !w_nextInvalid;
        w_nextMemDir = w_nextDir;
`endif
    end

    // A lane retires on a write handshake, or at once when no write is issued for it.
    always_comb begin
        w_retire = !r_memWe || mem_ready;
    end

    // Sequencer FSM: accept a bundle, walk lanes 0..8, pulse done, return to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_addrs         <= '0;
            r_fPost         <= '0;
            r_src           <= '0;
            r_dir           <= '0;
            r_laneInvalid   <= 1'b0;
            r_inReady       <= 1'b1;
            r_memWe         <= 1'b0;
            r_memDir        <= '0;
            r_memAddr       <= '0;
            r_memData       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_boundaryCount <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_addrs       <= write_addresses;
                        r_fPost       <= f_post;
                        r_src         <= src_addr;
                        r_dir         <= w_nextDir;
                        r_laneInvalid <= w_nextInvalid;
                        r_memWe       <= w_nextWe;
                        r_memDir      <= w_nextMemDir;
                        r_memAddr     <= w_nextMemAddr;
                        r_memData     <= w_nextMemData;
                        r_inReady     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= LANE;
                    end
                end
                LANE: begin
                    if (w_retire) begin
                        if (r_laneInvalid && (r_boundaryCount != 16'hFFFF)) begin
                            r_boundaryCount <= r_boundaryCount + 16'd1;
                        end
                        if (r_dir == 4'd8) begin
                            r_memWe   <= 1'b0;
                            r_memDir  <= '0;
                            r_memAddr <= '0;
                            r_memData <= '0;
                            r_done    <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_dir         <= w_nextDir;
                            r_laneInvalid <= w_nextInvalid;
                            r_memWe       <= w_nextWe;
                            r_memDir      <= w_nextMemDir;
                            r_memAddr     <= w_nextMemAddr;
                            r_memData     <= w_nextMemData;
                        end
                    end
                end
                DONE: begin
                    r_inReady <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_inReady <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign in_ready       = r_inReady;
    assign mem_we         = r_memWe;
    assign mem_dir        = r_memDir;
    assign mem_addr       = r_memAddr;
    assign mem_data       = r_memData;
    assign busy           = r_busy;
    assign done           = r_done;
    assign boundary_count = r_boundaryCount;

endmodule

// File: tb/tb_stream_write_sequencer.sv
// tb_stream_write_sequencer: table-driven checks of stream_write_sequencer,
// plus hand-written sequences for reset mid-bundle. Expectations for the
// corner bundle follow BOUNCE_BACK_EN when it is defined.
module tb_stream_write_sequencer;

    localparam int AW = 9;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [9*AW-1:0] write_addresses;
    logic [9*DW-1:0] f_post;
    logic [AW-2:0]   src_addr;
    logic            mem_we;
    logic [3:0]      mem_dir;
    logic [AW-2:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;
    logic            busy;
    logic            done;
    logic [15:0]     boundary_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic inValid;
        int   sel;
        logic memReady;
        logic expWe;
        int   expDir;
        int   expAddr;
        int   expData;
        logic expDone;
        logic expInReady;
    } vec_t;

    vec_t        vecs[$];
    logic [8:0]  bAddr[3][9];
    logic [15:0] bData[3][9];
    logic [7:0]  bSrc[3];
    int          cornerDir[9];

    stream_write_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .write_addresses(write_addresses),
        .f_post         (f_post),
        .src_addr       (src_addr),
        .mem_we         (mem_we),
        .mem_dir        (mem_dir),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .busy           (busy),
        .done           (done),
        .boundary_count (boundary_count)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic inValid, input int sel, input logic memReady, input logic we,
                          input int dir, input int addr, input int data, input logic dn, input logic rdy);
        vec_t v;
        v.inValid    = inValid;
        v.sel        = sel;
        v.memReady   = memReady;
        v.expWe      = we;
        v.expDir     = dir;
        v.expAddr    = addr;
        v.expData    = data;
        v.expDone    = dn;
        v.expInReady = rdy;
        vecs.push_back(v);
    endtask

    task automatic addLane(input logic inValid, input int sel, input logic memReady, input int d);
        addVec(inValid, sel, memReady, 1'b1, d, int'(bAddr[sel][d][7:0]), int'(bData[sel][d]), 1'b0, 1'b0);
    endtask

    task automatic driveBundle(input int sel);
        for (int d = 0; d < 9; d++) begin
            write_addresses[(8-d)*AW +: AW] = bAddr[sel][d];
            f_post[(8-d)*DW +: DW]          = bData[sel][d];
        end
        src_addr = bSrc[sel];
    endtask

    task automatic checkOutput(input string label, input int idx, input vec_t v);
        checkValue($sformatf("%s[%0d] mem_we", label, idx), 32'(mem_we), 32'(v.expWe));
        if (v.expWe) begin
            checkValue($sformatf("%s[%0d] mem_dir", label, idx), 32'(mem_dir), v.expDir);
            checkValue($sformatf("%s[%0d] mem_addr", label, idx), 32'(mem_addr), v.expAddr);
            checkValue($sformatf("%s[%0d] mem_data", label, idx), 32'(mem_data), v.expData);
        end
        checkValue($sformatf("%s[%0d] done", label, idx), 32'(done), 32'(v.expDone));
        checkValue($sformatf("%s[%0d] in_ready", label, idx), 32'(in_ready), 32'(v.expInReady));
        checkValue($sformatf("%s[%0d] busy", label, idx), 32'(busy), 32'(!v.expInReady));
    endtask

    // Each vector: drive inputs for this cycle, check registered outputs, advance one clock.
    task automatic applyStimulus(input string label);
        for (int i = 0; i < vecs.size(); i++) begin
            mem_ready = vecs[i].memReady;
            in_valid  = vecs[i].inValid;
            driveBundle(vecs[i].sel);
            #1;
            checkOutput(label, i, vecs[i]);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        vecs.delete();
    endtask

    task automatic buildInterior(input int sel);
        addVec(1'b1, sel, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int d = 0; d < 9; d++) addLane(1'b0, sel, 1'b1, d);
        addVec(1'b0, sel, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        addVec(1'b0, sel, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        bAddr[0] = '{9'd85, 9'd86, 9'd101, 9'd84, 9'd69, 9'd102, 9'd100, 9'd68, 9'd70};
        bData[0] = '{16'h3E81, 16'h0A32, 16'h0A43, 16'h0A54, 16'h0A65, 16'h0286, 16'h0297, 16'h02A8, 16'h02B9};
        bSrc[0]  = 8'd85;
        bAddr[1] = '{9'd0, 9'd1, 9'd16, 9'h1FF, 9'h1FF, 9'd17, 9'h1FF, 9'h1FF, 9'h1FF};
        bData[1] = '{16'h5010, 16'h5021, 16'h5032, 16'h5043, 16'h5054, 16'h5065, 16'h5076, 16'h5087, 16'h5098};
        bSrc[1]  = 8'd0;
        bAddr[2] = '{9'd170, 9'd171, 9'd186, 9'd169, 9'd154, 9'd187, 9'd185, 9'd153, 9'd155};
        bData[2] = '{16'h7101, 16'h7212, 16'h7323, 16'h7434, 16'h7545, 16'h7656, 16'h7767, 16'h7878, 16'h7989};
        bSrc[2]  = 8'd170;
        cornerDir = '{0, 1, 2, 1, 2, 5, 8, 5, 6};

        reset     = 1'b1;
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        driveBundle(0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values.
        checkValue("reset in_ready", 32'(in_ready), 32'd1);
        checkValue("reset mem_we", 32'(mem_we), 32'd0);
        checkValue("reset mem_dir", 32'(mem_dir), 32'd0);
        checkValue("reset mem_addr", 32'(mem_addr), 32'd0);
        checkValue("reset mem_data", 32'(mem_data), 32'd0);
        checkValue("reset busy", 32'(busy), 32'd0);
        checkValue("reset done", 32'(done), 32'd0);
        checkValue("reset boundary_count", 32'(boundary_count), 32'd0);

        // Interior node, every lane valid, memory always ready.
        buildInterior(0);
        applyStimulus("interior");
        checkValue("interior boundary_count", 32'(boundary_count), 32'd0);

        // Corner node: lanes 3,4,6,7,8 are out of the grid.
        addVec(1'b1, 1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int d = 0; d < 9; d++) begin
            if (d == 3 || d == 4 || d >= 6) begin
`ifdef BOUNCE_BACK_EN
                addVec(1'b0, 1, 1'b1, 1'b1, cornerDir[d], 0, int'(bData[1][d]), 1'b0, 1'b0);
`else
                addVec(1'b0, 1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
`endif
            end else begin
                addLane(1'b0, 1, 1'b1, d);
            end
        end
        addVec(1'b0, 1, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        addVec(1'b0, 1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        applyStimulus("corner");
        checkValue("corner boundary_count", 32'(boundary_count), 32'd5);

        // Memory stalls three cycles on lane 2; done moves to T+13.
        addVec(1'b1, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        addLane(1'b0, 0, 1'b1, 0);
        addLane(1'b0, 0, 1'b1, 1);
        addLane(1'b0, 0, 1'b0, 2);
        addLane(1'b0, 0, 1'b0, 2);
        addLane(1'b0, 0, 1'b0, 2);
        addLane(1'b0, 0, 1'b1, 2);
        for (int d = 3; d < 9; d++) addLane(1'b0, 0, 1'b1, d);
        addVec(1'b0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        addVec(1'b0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        applyStimulus("stall");
        checkValue("stall boundary_count", 32'(boundary_count), 32'd5);

        // Reset while lane 4 is presented: bundle dropped, no done pulse.
        addVec(1'b1, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int d = 0; d < 4; d++) addLane(1'b0, 0, 1'b1, d);
        applyStimulus("preReset");
        reset = 1'b1;
        #1;
        checkValue("midReset lane4 mem_dir", 32'(mem_dir), 32'd4);
        checkValue("midReset lane4 mem_we", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkValue("postReset mem_we", 32'(mem_we), 32'd0);
        checkValue("postReset in_ready", 32'(in_ready), 32'd1);
        checkValue("postReset busy", 32'(busy), 32'd0);
        checkValue("postReset mem_dir", 32'(mem_dir), 32'd0);
        checkValue("postReset boundary_count", 32'(boundary_count), 32'd0);
        begin
            logic sawDone;
            sawDone = done;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                if (done) sawDone = 1'b1;
            end
            checkValue("postReset no done pulse", 32'(sawDone), 32'd0);
        end

        // A fresh bundle after the reset completes normally.
        buildInterior(2);
        applyStimulus("fresh");
        checkValue("fresh boundary_count", 32'(boundary_count), 32'd0);

        // in_valid held high; inputs change mid-bundle and must not disturb it.
        addVec(1'b1, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        addLane(1'b1, 0, 1'b1, 0);
        addLane(1'b1, 0, 1'b1, 1);
        for (int d = 2; d < 9; d++) addLane(1'b1, 2, 1'b1, d);
        for (int d = 2; d < 9; d++) begin
            vecs[d+1].expAddr = int'(bAddr[0][d][7:0]);
            vecs[d+1].expData = int'(bData[0][d]);
        end
        addVec(1'b1, 2, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        addVec(1'b1, 2, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int d = 0; d < 9; d++) addLane(1'b0, 2, 1'b1, d);
        addVec(1'b0, 2, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        addVec(1'b0, 2, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        applyStimulus("backToBack");
        checkValue("backToBack boundary_count", 32'(boundary_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
